// File: rtl/ifu_prefetch.sv
// ifu_prefetch -- decoupled instruction-fetch front end.
//
// Issues one word fetch at a time to instruction memory, buffers the returned
// {pc, instruction} pairs in a small FIFO and hands them to decode over a
// valid/ready handshake. A redirect from execute flushes the FIFO, retargets
// the fetch PC and, if a fetch is still in flight, arranges for its response
// to be thrown away when it eventually arrives.
//
// Ports:
//   clk, rst                       clock; synchronous active-low reset
//   imem_req_valid/ready/addr      fetch request channel (word aligned address)
//   imem_rsp_valid/data            fetch response, always accepted
//   redirect_valid/pc              taken branch/jump target (bits [1:0] ignored)
//   dec_valid/ready/pc/instr       head of the prefetch FIFO towards decode
//   busy                           a fetch is outstanding or being discarded
module ifu_prefetch #(
  parameter int            AW       = 32,
  parameter int            DEPTH    = 4,
  parameter logic [AW-1:0] RESET_PC = 'h0000_3000
) (
  input  logic          clk,
  input  logic          rst,
  output logic          imem_req_valid,
  input  logic          imem_req_ready,
  output logic [AW-1:0] imem_req_addr,
  input  logic          imem_rsp_valid,
  input  logic [31:0]   imem_rsp_data,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_pc,
  output logic          dec_valid,
  input  logic          dec_ready,
  output logic [AW-1:0] dec_pc,
  output logic [31:0]   dec_instr,
  output logic          busy
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] L_DEPTH = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [AW-1:0]   r_fetch_pc;
  logic [AW-1:0]   r_req_pc;
  logic [PW-1:0]   r_rd_ptr;
  logic [PW-1:0]   r_wr_ptr;
  logic [PW:0]     r_count;
  logic [PW:0]     w_count_next;

  logic [AW-1:0]   r_pc_mem    [DEPTH];
  logic [31:0]     r_instr_mem [DEPTH];

  logic            w_req_valid;
  logic            w_req_fire;
  logic            w_push;
  logic            w_pop;
  logic [AW-1:0]   w_req_addr;
  logic            w_unused;

  // Redirect targets may carry byte-offset bits; they are dropped on purpose.
  assign w_unused = ^redirect_pc[1:0];

  assign w_req_addr = {r_fetch_pc[AW-1:2], 2'b00};

  // Credit rule: only request while a FIFO slot is guaranteed for the answer.
  // A redirect suppresses the request so the old stream never leaks out.
  assign w_req_valid = rst && (r_state == S_IDLE) && (r_count != L_DEPTH)
                       && !redirect_valid;
  assign w_req_fire  = w_req_valid && imem_req_ready;

  // Responses only land in WAIT; in DISCARD (or with a redirect the same
  // cycle) the data belongs to a squashed path.
  assign w_push = (r_state == S_WAIT) && imem_rsp_valid && !redirect_valid;
  assign w_pop  = (r_count != '0) && dec_ready && !redirect_valid;

  assign imem_req_valid = w_req_valid;
  assign imem_req_addr  = w_req_addr;
  assign dec_valid      = (r_count != '0);
  assign dec_pc         = r_pc_mem[r_rd_ptr];
  assign dec_instr      = r_instr_mem[r_rd_ptr];
  assign busy           = (r_state != S_IDLE);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_req_fire) w_state_next = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rsp_valid)      w_state_next = S_IDLE;
        else if (redirect_valid) w_state_next = S_DISCARD;
      end
      S_DISCARD: begin
        if (imem_rsp_valid) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + 1'b1;
      2'b01:   w_count_next = r_count - 1'b1;
      default: w_count_next = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_fetch_pc <= RESET_PC;
      r_req_pc   <= RESET_PC;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_req_fire) r_req_pc <= w_req_addr;
      if (redirect_valid) begin
        r_fetch_pc <= {redirect_pc[AW-1:2], 2'b00};
        r_rd_ptr   <= '0;
        r_wr_ptr   <= '0;
        r_count    <= '0;
      end else begin
        if (w_req_fire) r_fetch_pc <= r_fetch_pc + AW'(4);
        if (w_push)     r_wr_ptr   <= r_wr_ptr + 1'b1;
        if (w_pop)      r_rd_ptr   <= r_rd_ptr + 1'b1;
        r_count <= w_count_next;
      end
    end
  end

  // Storage carries no reset: entries are only visible through r_count.
  always_ff @(posedge clk) begin
    if (rst && w_push) begin
      r_pc_mem[r_wr_ptr]    <= r_req_pc;
      r_instr_mem[r_wr_ptr] <= imem_rsp_data;
    end
  end

endmodule

// File: doc/ifu_prefetch.md
Name: ifu_prefetch

Overview:
- Decoupled instruction-fetch front end for the MIPS core. Sits between instruction memory and the decode/controller stage.
- Issues word fetches over a valid/ready request channel and accepts variable-latency responses.
- Buffers {pc, instruction} pairs in a small FIFO and presents them to decode over a valid/ready handshake.
- Accepts branch/jump redirects from execute, flushing queued and in-flight fetches.

Parameters:
- RESET_PC, 32'h0000_3000, first fetch address after reset.
- DEPTH, 4, prefetch FIFO entries; power of two, 2..16.
- AW, 32, address width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request this cycle.
- imem_req_addr  out  AW  word-aligned fetch address.
- imem_rsp_valid  in  1  response data valid; always accepted.
- imem_rsp_data  in  32  fetched instruction word.
- redirect_valid  in  1  taken branch/jump this cycle.
- redirect_pc  in  AW  redirect target; bits [1:0] ignored.
- dec_valid  out  1  FIFO head valid.
- dec_ready  in  1  decode consumes head.
- dec_pc  out  AW  PC of head instruction.
- dec_instr  out  32  head instruction word.
- busy  out  1  request outstanding (state != IDLE).

Behaviour:
- Reset (rst==0 at posedge): fetch_pc=RESET_PC, FIFO empty (rd_ptr=wr_ptr=count=0), state=IDLE, discard=0.
  - Outputs after reset: imem_req_valid=0 that cycle, dec_valid=0, busy=0.
  - Reset overrides every other input, including a response arriving mid-fetch. That response is not written.
- At most one outstanding request. States:
  - IDLE: imem_req_valid=1 iff count<DEPTH and redirect_valid==0. On valid&&ready, go to WAIT, record req_pc=fetch_pc, and set fetch_pc+=4 (wraps modulo 2^AW).
  - WAIT: imem_req_valid=0. On imem_rsp_valid, push {req_pc, imem_rsp_data} and go to IDLE.
  - DISCARD: imem_req_valid=0. On imem_rsp_valid, drop the data, clear discard, and go to IDLE.
- imem_req_addr = fetch_pc with bits [1:0] forced to 0. It is held stable while valid && !ready.
- Credit rule: a request is issued only if count<DEPTH at issue time. This guarantees the FIFO cannot overflow on response.
- A response arriving in the same cycle as a request issue is impossible (single outstanding). A response in IDLE is ignored.
- Decode handshake:
  - dec_valid = (count!=0).
  - dec_pc and dec_instr come from the head entry, driven combinationally from the FIFO.
  - Pop on dec_valid && dec_ready.
  - Push and pop in the same cycle leave count unchanged.
  - When full, a pop frees a slot; the next request issues the following cycle.
- Redirect (redirect_valid==1, rst==1) has highest priority:
  - FIFO is flushed: count=0, rd_ptr=wr_ptr=0. Any simultaneous pop or push is void.
  - fetch_pc = {redirect_pc[AW-1:2], 2'b00}.
  - WAIT with no response this cycle goes to DISCARD.
  - WAIT with a response this cycle goes to IDLE and the data is dropped.
  - DISCARD stays in DISCARD, or goes to IDLE if a response arrives this cycle.
  - IDLE stays in IDLE. No request is issued that cycle; imem_req_valid is forced to 0.
  - Back-to-back redirects: the last one wins. Only one discard is pending.
- Latency: redirect at cycle N gives earliest imem_req_valid at N+1. With zero-wait memory (ready=1 and response the cycle after acceptance), the first dec_valid comes at N+3.
- Throughput: one instruction per 2 cycles with 1-cycle memory latency.
- dec_* outputs are unaffected by imem_* in the same cycle. There is no combinational path from imem_rsp to dec_valid.

Test Plan:
- Reset then free-run with ready=1 and 1-cycle response from a ROM holding word=addr^32'hA5A5_0000 -> dec_pc sequence 0x3000, 0x3004, 0x3008... with matching data. First dec_valid is 3 cycles after rst deasserts.
- Hold dec_ready=0 -> exactly DEPTH=4 requests issued (0x3000..0x300C), then imem_req_valid=0. Pulse dec_ready for 1 cycle -> one request at 0x3010 the next cycle.
- imem_req_ready=0 for 5 cycles -> imem_req_addr stays 0x3000 and valid stays high. No response is consumed.
- Redirect to 0x0000_4002 while a request is outstanding and the response is 3 cycles late -> late response dropped, FIFO empty, next request addr 0x4000, dec_pc 0x4000.
- Redirect in the same cycle as imem_rsp_valid and a dec pop -> data dropped, count=0, state IDLE. Next request is at the target.
- rst=0 asserted while in WAIT with a response in the same cycle -> dec_valid=0, next request addr 0x3000. fetch_pc at 0xFFFF_FFFC wraps to 0x0000_0000.
